// File: rtl/page_walker_if.sv
// page_walker_if: bundles the TLB refill handshake and the PTE read port of the
// page walker.
//   slave  modport: walker side. It answers TLB misses and masters the memory read.
//   master modport: environment side, meaning the TLB and the memory.
// Signals:
//   fault/compare_input/ptbr           TLB miss request, faulting VA and table base
//   fault_input/unfault/page_fault     refill result, refill strobe and fault pulse
//   fault_address/busy                 latched VA and walk-in-progress flag
//   mem_read/mem_address/mem_data/mem_ready   ready-based PTE read port
interface page_walker_if #(
   parameter int unsigned BitCount = 32
);
   logic                fault;
   logic [BitCount-1:0] compare_input;
   logic [BitCount-1:0] ptbr;
   logic [BitCount-1:0] fault_input;
   logic                unfault;
   logic                page_fault;
   logic [BitCount-1:0] fault_address;
   logic                busy;
   logic                mem_read;
   logic [BitCount-1:0] mem_address;
   logic [BitCount-1:0] mem_data;
   logic                mem_ready;

   modport slave (
      input  fault, compare_input, ptbr, mem_data, mem_ready,
      output fault_input, unfault, page_fault, fault_address, busy, mem_read, mem_address
   );

   modport master (
      output fault, compare_input, ptbr, mem_data, mem_ready,
      input  fault_input, unfault, page_fault, fault_address, busy, mem_read, mem_address
   );
endinterface

// File: rtl/page_walker.sv
// page_walker: two-level page-table walker that services TLB misses.
// On a miss it reads an L1 and an L2 PTE and returns {PPN, VA offset} with a
// one-cycle unfault strobe. An invalid PTE at either level gives a one-cycle
// page_fault pulse instead of a refill.
// Ports:
//   i_clk    clock. All logic runs on the rising edge.
//   i_rst    synchronous, active-high reset.
//   io_walk  page_walker_if.slave. It carries the TLB handshake and the memory read port.
// PTE format: bit 0 is V, and bits [BitCount-1:Ow] hold the PPN.
module page_walker #(
   parameter int unsigned BitCount = 32,
   parameter int unsigned PageSize = 4096
) (
   input  logic          i_clk,
   input  logic          i_rst,
   page_walker_if.slave  io_walk
);

   localparam int unsigned Ow = $clog2(PageSize);
   localparam int unsigned Iw = (BitCount - Ow) / 2;

   typedef enum logic [2:0] {
      StIdle,
      StL1Read,
      StL2Read,
      StRespond,
      StWaitClear
   } state_e;

   state_e              r_state;
   logic [BitCount-1:0] r_va;
   logic [BitCount-1:0] r_fault_input;
   logic                r_unfault;
   logic                r_page_fault;
   logic                r_busy;
   logic                r_mem_read;
   logic [BitCount-1:0] r_mem_address;

   logic [BitCount-1:0] w_l1_addr;
   logic [BitCount-1:0] w_l2_addr;
   logic                w_pte_valid;
   logic                w_unused_pte;

   // The L1 address is built from the live request, so latching ptbr is the same
   // as latching this address into r_mem_address at walk start.
   assign w_l1_addr = io_walk.ptbr
                    + BitCount'({io_walk.compare_input[BitCount-1 -: Iw], 2'b00});
   assign w_l2_addr = {io_walk.mem_data[BitCount-1:Ow], Ow'(0)}
                    + BitCount'({r_va[BitCount-Iw-1 -: Iw], 2'b00});
   assign w_pte_valid  = io_walk.mem_data[0];
   assign w_unused_pte = ^io_walk.mem_data[Ow-1:1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_va          <= '0;
         r_fault_input <= '0;
         r_unfault     <= 1'b0;
         r_page_fault  <= 1'b0;
         r_busy        <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_address <= '0;
      end else begin
         r_unfault    <= 1'b0;
         r_page_fault <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (io_walk.fault) begin
                  r_va          <= io_walk.compare_input;
                  r_mem_read    <= 1'b1;
                  r_mem_address <= w_l1_addr;
                  r_busy        <= 1'b1;
                  r_state       <= StL1Read;
               end
            end
            StL1Read: begin
               if (io_walk.mem_ready) begin
                  if (!w_pte_valid) begin
                     r_page_fault <= 1'b1;
                     r_mem_read   <= 1'b0;
                     r_state      <= StWaitClear;
                  end else begin
                     // mem_read stays high so the L2 read follows back-to-back.
                     r_mem_address <= w_l2_addr;
                     r_state       <= StL2Read;
                  end
               end
            end
            StL2Read: begin
               if (io_walk.mem_ready) begin
                  r_mem_read <= 1'b0;
                  if (!w_pte_valid) begin
                     r_page_fault <= 1'b1;
                     r_state      <= StWaitClear;
                  end else begin
                     r_fault_input <= {io_walk.mem_data[BitCount-1:Ow], r_va[Ow-1:0]};
                     r_unfault     <= 1'b1;
                     r_state       <= StRespond;
                  end
               end
            end
            StRespond: begin
               r_state <= StWaitClear;
            end
            StWaitClear: begin
               // The TLB keeps fault high after a refill. Only a dropped fault or a
               // different VA can start the next walk.
               if (!io_walk.fault || (io_walk.compare_input != r_va)) begin
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end
            end
            default: begin
               r_busy     <= 1'b0;
               r_mem_read <= 1'b0;
               r_state    <= StIdle;
            end
         endcase
      end
   end

   assign io_walk.fault_input   = r_fault_input;
   assign io_walk.unfault       = r_unfault;
   assign io_walk.page_fault    = r_page_fault;
   assign io_walk.fault_address = r_va;
   assign io_walk.busy          = r_busy;
   assign io_walk.mem_read      = r_mem_read;
   assign io_walk.mem_address   = r_mem_address;

endmodule

// File: doc/page_walker.md
# page_walker

Two-level hardware page-table walker that services TLB misses. It is the responder on the TLB `fault`/`unfault` refill handshake. On a miss it reads two page-table entries from memory through a ready-based read port and returns the physical address on `fault_input` with a one-cycle `unfault` pulse. If either entry is invalid, it raises `page_fault` and does not refill.

## Interface
- `bit_count`, 32: address/data/PTE width (cpu_params); (bit_count − log2(page_size)) must be even.
- `page_size`, 4096: page size in bytes; offset width `ow` = log2(page_size) = 12.
- Derived: index width `iw` = (bit_count − ow)/2 = 10. VA fields are L1 index [31:22], L2 index [21:12], offset [11:0].
- `clk` input 1: clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `fault` input 1: TLB miss request, level.
- `compare_input` input bit_count: faulting virtual address from the requester.
- `ptbr` input bit_count: page-table base (page aligned), sampled at walk start.
- `fault_input` output bit_count: translated physical address {PPN, VA offset}.
- `unfault` output 1: refill strobe, exactly one cycle per successful walk.
- `page_fault` output 1: one-cycle pulse on an invalid PTE.
- `fault_address` output bit_count: latched VA of the current or last walk.
- `busy` output 1: high in every state except IDLE.
- `mem_read` output 1: memory read request.
- `mem_address` output bit_count: byte address of the PTE.
- `mem_data` input bit_count: read data, valid when `mem_ready`=1.
- `mem_ready` input 1: completes the current read.

## Operation
- PTE format: bit 0 is V (valid); bits [31:12] are the PPN; all other bits are ignored.
- States are IDLE, L1_READ, L2_READ, RESPOND and WAIT_CLEAR.
- IDLE:
  - If `fault`=1, latch `compare_input` into the VA register and `fault_address`, and latch `ptbr`.
  - Then go to L1_READ.
- L1_READ:
  - `mem_read`=1, `mem_address` = ptbr + (VA[31:22] << 2), modulo 2^bit_count.
  - On `mem_ready`=1, capture `mem_data`.
  - If V=0: pulse `page_fault` and go to WAIT_CLEAR.
  - If V=1: set the L2 base to {PPN, 12'b0} and go to L2_READ.
- L2_READ:
  - `mem_address` = L2 base + (VA[21:12] << 2).
  - On `mem_ready`=1: if V=0, pulse `page_fault` and go to WAIT_CLEAR.
  - If V=1: load `fault_input` = {mem_data[31:12], VA[11:0]} and go to RESPOND.
- RESPOND: `unfault`=1 for this single cycle, then go to WAIT_CLEAR.
- WAIT_CLEAR:
  - Return to IDLE when `fault`=0 or `compare_input` ≠ latched VA.
  - This prevents re-walking a stale request, because the TLB holds `fault` high after a refill.
  - Because of this check, a new miss with a different VA while `fault` stays high restarts via IDLE.
- Memory rules:
  - `mem_address` is stable while `mem_read`=1 and no `mem_ready` has been seen.
  - `mem_ready` completes the request in the cycle it is high.
  - `mem_ready` while `mem_read`=0 is ignored.
  - Back-to-back requests are allowed: L1→L2 keeps `mem_read` high with the new address.
- `fault_input` holds its value until the next successful walk; `page_fault` never coincides with `unfault`.
- `fault` dropping mid-walk does not abort the walk; the walk completes normally.

## Timing
- Reset values: state IDLE; `mem_read`, `unfault`, `page_fault` and `busy` at 0; `mem_address`, `fault_input` and `fault_address` at 0.
- A walk starts when `fault`=1 is sampled in IDLE at edge k. `mem_read`=1 from cycle k+1.
- Zero-wait memory (`mem_ready` in the first request cycle):
  - L1 read in cycle k+1, L2 read in cycle k+2.
  - `unfault`=1 in cycle k+3, with `fault_input` already valid in that cycle.
- Each memory wait cycle adds one cycle to the latency.
- An L1 page fault pulses `page_fault` in the cycle after the L1 ready (k+2 with zero wait).
- Minimum gap between two walks: WAIT_CLEAR plus IDLE, two cycles.
- `rst` at any point, including mid-read:
  - All outputs take their reset values after the edge.
  - A `mem_ready` arriving after reset is ignored.

## Test plan
- Refill with zero-wait memory:
  - Setup: ptbr=0x0000_1000, VA=0xFFFF_F00A, mem[0x1FFC]=0x0000_2001, mem[0x2FFC]=0x1000_0001.
  - Required: reads at 0x1FFC then 0x2FFC; `unfault` in cycle k+3 with `fault_input`=0x1000_000A.
- Same walk with 2 wait cycles per read:
  - Required: `unfault` at k+7; `mem_address` stable during the waits.
- Invalid L1 PTE (mem[0x1FFC]=0x0000_2000):
  - Required: one `page_fault` pulse; no L2 read; no `unfault`; `fault_address`=0xFFFF_F00A.
- Invalid L2 PTE: `page_fault` pulse after the second read; `fault_input` keeps its previous value.
- Re-arm with `fault` held high:
  - Stimulus: after the refill, `compare_input` changes to 0x0040_0123.
  - Required: a second walk starts; `fault` held high with an unchanged VA causes no new walk.
- Reset in L2_READ: `mem_read`=0 and `busy`=0 after the edge; a late `mem_ready` causes no `unfault`.
